// File: rtl/fifo_pkg.sv
// Shared helpers for both FIFO domain controllers: Gray/binary conversion,
// address-width derivation and the default geometry.
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int PTR_MAX_W  = 32;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Both conversions work at PTR_MAX_W; callers cast to their pointer width.
    // The zero upper bits do not disturb the result.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the FIFO: memory read port plus the consumer valid/ready stream.
interface fifo_rd_ctrl_if
    import fifo_pkg::*;
#(
    parameter int WIDTH  = FIFO_WIDTH,
    parameter int ADDR_W = addr_w(FIFO_DEPTH)
);
    logic [ADDR_W-1:0] raddr;
    logic              rclk_en;
    logic [WIDTH-1:0]  rdata_mem;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output raddr, rclk_en, rd_data, rd_valid,
        input  rdata_mem, rd_ready
    );

    modport slave (
        input  raddr, rclk_en, rd_data, rd_valid,
        output rdata_mem, rd_ready
    );
endinterface

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchroniser for a Gray pointer crossing into this clock domain.
module ptr_sync_2ff #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] s1_q, s2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the dual-clock FIFO: syncs the write pointer,
// derives empty/level, pops memory into a registered valid/ready output stage.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter  int WIDTH  = FIFO_WIDTH,
    parameter  int DEPTH  = FIFO_DEPTH,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              R_CLK,
    input  logic              R_RST,
    input  logic [ADDR_W:0]   wptr_gray,
    output logic [ADDR_W:0]   rptr_gray,
    output logic              empty,
    output logic [ADDR_W:0]   rd_count,
    fifo_rd_ctrl_if.master    bus
);
    logic [ADDR_W:0]  wq2, wbin_s;
    logic [ADDR_W:0]  rbin_q, rbin_d;
    logic [ADDR_W:0]  rgray_q, rgray_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             pop;

    ptr_sync_2ff #(.W(ADDR_W + 1)) u_wsync (
        .clk   (R_CLK),
        .rst_n (R_RST),
        .d_i   (wptr_gray),
        .q_o   (wq2)
    );

    assign wbin_s   = (ADDR_W + 1)'(gray2bin(PTR_MAX_W'(wq2)));
    assign empty    = (rgray_q == wq2);
    assign rd_count = wbin_s - rbin_q;

    // Refill the output register whenever it is free or being drained this cycle.
    assign pop = R_RST & ~empty & (~rd_valid_q | bus.rd_ready);

    always_comb begin
        rbin_d     = rbin_q + {{ADDR_W{1'b0}}, pop};
        rgray_d    = (ADDR_W + 1)'(bin2gray(PTR_MAX_W'(rbin_d)));
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        if (pop) begin
            rd_data_d  = bus.rdata_mem;
            rd_valid_d = 1'b1;
        end else if (bus.rd_ready) begin
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge R_CLK) begin
        if (!R_RST) begin
            rbin_q     <= '0;
            rgray_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rbin_q     <= rbin_d;
            rgray_q    <= rgray_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rptr_gray    = rgray_q;
    assign bus.raddr    = rbin_q[ADDR_W-1:0];
    assign bus.rclk_en  = pop;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl (WIDTH=8, DEPTH=16) with a behavioural memory.
module tb_fifo_rd_ctrl;
    logic       R_CLK = 1'b0;
    logic       R_RST;
    logic [4:0] wptr_gray, rptr_gray, rd_count;
    logic       empty;
    logic [7:0] mem [16];
    int         nvec = 0;
    int         nerr = 0;

    always #5 R_CLK = ~R_CLK;

    fifo_rd_ctrl_if #(.WIDTH(8), .ADDR_W(4)) bus ();

    assign bus.rdata_mem = mem[bus.raddr];

    fifo_rd_ctrl #(.WIDTH(8), .DEPTH(16)) dut (
        .R_CLK     (R_CLK),
        .R_RST     (R_RST),
        .wptr_gray (wptr_gray),
        .rptr_gray (rptr_gray),
        .empty     (empty),
        .rd_count  (rd_count),
        .bus       (bus.master)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge R_CLK);
        #1;
    endtask

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    function automatic int gray5_to_bin(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return int'(b);
    endfunction

    function automatic logic [7:0] wval(input int k);
        return 8'(k * 37 + 5);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int wcnt, rcnt, wraps;
        logic [3:0] prev;

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        R_RST = 1'b0;
        wptr_gray = 5'b00011;
        bus.rd_ready = 1'b0;

        // Reset
        tick(); tick();
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rclk_en", 32'(bus.rclk_en), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_raddr", 32'(bus.raddr), 32'd0);
        chk("rst_rptr", 32'(rptr_gray), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_count", 32'(rd_count), 32'd0);
        wptr_gray = 5'b00000;
        R_RST = 1'b1;
        tick();

        // Single word
        mem[0] = 8'hA5;
        wptr_gray = 5'b00001;
        bus.rd_ready = 1'b1;
        tick();
        chk("single_empty_e1", 32'(empty), 32'd1);
        tick();
        chk("single_empty_e2", 32'(empty), 32'd0);
        chk("single_pop", 32'(bus.rclk_en), 32'd1);
        chk("single_raddr", 32'(bus.raddr), 32'd0);
        tick();
        chk("single_data", 32'(bus.rd_data), 32'hA5);
        chk("single_valid", 32'(bus.rd_valid), 32'd1);
        chk("single_rptr", 32'(rptr_gray), 32'b00001);
        chk("single_empty_after", 32'(empty), 32'd1);
        chk("single_no_pop", 32'(bus.rclk_en), 32'd0);
        tick();
        chk("single_consumed", 32'(bus.rd_valid), 32'd0);

        // Backpressure
        bus.rd_ready = 1'b0;
        mem[1] = 8'h11;
        mem[2] = 8'h22;
        wptr_gray = 5'b00010;
        tick(); tick();
        chk("bp_count_pre", 32'(rd_count), 32'd2);
        chk("bp_pop", 32'(bus.rclk_en), 32'd1);
        chk("bp_raddr", 32'(bus.raddr), 32'd1);
        tick();
        chk("bp_data", 32'(bus.rd_data), 32'h11);
        chk("bp_count_post", 32'(rd_count), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_data", 32'(bus.rd_data), 32'h11);
            chk("bp_hold_valid", 32'(bus.rd_valid), 32'd1);
            chk("bp_hold_no_pop", 32'(bus.rclk_en), 32'd0);
        end
        bus.rd_ready = 1'b1;
        #1;
        chk("bp_release_pop", 32'(bus.rclk_en), 32'd1);
        chk("bp_release_raddr", 32'(bus.raddr), 32'd2);
        tick();
        chk("bp_word2", 32'(bus.rd_data), 32'h22);
        chk("bp_word2_valid", 32'(bus.rd_valid), 32'd1);
        tick();
        chk("bp_drained", 32'(bus.rd_valid), 32'd0);
        chk("bp_empty", 32'(empty), 32'd1);

        // Full occupancy from rbin=0
        R_RST = 1'b0;
        wptr_gray = 5'b00000;
        bus.rd_ready = 1'b0;
        tick();
        R_RST = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h40 + i);
        wptr_gray = 5'b11000;
        tick(); tick();
        chk("full_count", 32'(rd_count), 32'd16);
        chk("full_empty", 32'(empty), 32'd0);
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("full_pop", 32'(bus.rclk_en), 32'd1);
            chk("full_raddr", 32'(bus.raddr), 32'(i));
            if (i > 0) chk("full_data", 32'(bus.rd_data), 32'(8'h40 + i - 1));
            tick();
        end
        chk("full_last_data", 32'(bus.rd_data), 32'h4F);
        chk("full_last_valid", 32'(bus.rd_valid), 32'd1);
        chk("full_empty_end", 32'(empty), 32'd1);
        chk("full_rptr", 32'(rptr_gray), 32'b11000);
        tick();
        chk("full_drained", 32'(bus.rd_valid), 32'd0);

        // Continuous 40-word stream from rbin=0, wrapping twice
        R_RST = 1'b0;
        wptr_gray = 5'b00000;
        tick();
        R_RST = 1'b1;
        wcnt = 0; rcnt = 0; wraps = 0; prev = 4'd0;
        for (int cyc = 0; cyc < 300 && rcnt < 40; cyc++) begin
            if (bus.rd_valid) begin
                chk("wrap_data", 32'(bus.rd_data), 32'(wval(rcnt)));
                rcnt++;
            end
            if (bus.rclk_en) begin
                if (prev == 4'd15 && bus.raddr == 4'd0) wraps++;
                prev = bus.raddr;
            end
            if (wcnt < 40 && ((wcnt - gray5_to_bin(rptr_gray)) & 31) < 16) begin
                mem[wcnt % 16] = wval(wcnt);
                wcnt++;
                wptr_gray = gray5(wcnt);
            end
            tick();
        end
        chk("wrap_words", 32'(rcnt), 32'd40);
        chk("wrap_count", 32'(wraps), 32'd2);
        chk("wrap_rptr", 32'(rptr_gray), 32'b01100);
        chk("wrap_empty", 32'(empty), 32'd1);
        tick();

        // Mid-stream reset with a word held and 5 entries in memory
        bus.rd_ready = 1'b0;
        for (int k = 40; k < 46; k++) mem[k % 16] = wval(k);
        wptr_gray = 5'b01001;
        tick(); tick();
        chk("mid_pop", 32'(bus.rclk_en), 32'd1);
        tick();
        chk("mid_valid", 32'(bus.rd_valid), 32'd1);
        chk("mid_data", 32'(bus.rd_data), 32'(wval(40)));
        chk("mid_count", 32'(rd_count), 32'd5);
        R_RST = 1'b0;
        wptr_gray = 5'b00000;
        #1;
        chk("mid_rst_no_pop", 32'(bus.rclk_en), 32'd0);
        tick();
        chk("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("mid_rst_raddr", 32'(bus.raddr), 32'd0);
        chk("mid_rst_rptr", 32'(rptr_gray), 32'd0);
        chk("mid_rst_data", 32'(bus.rd_data), 32'd0);
        chk("mid_rst_count", 32'(rd_count), 32'd0);
        chk("mid_rst_rclk_en", 32'(bus.rclk_en), 32'd0);
        R_RST = 1'b1;
        tick();
        chk("mid_post_empty", 32'(empty), 32'd1);
        chk("mid_post_valid", 32'(bus.rd_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
